// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the add/sub accumulator sequencer: controller state
// encoding and the datapath drive values used when no operand is issued.
package addsub_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic HOLD_ADDSUB  = 1'b0;
    localparam logic SEL_LOAD     = 1'b0;
    localparam logic SEL_FEEDBACK = 1'b1;

    // Idle Sel value: feedback while a job's sum lives in Z, A path otherwise.
    function automatic logic hold_sel(input state_t s);
        logic sel;
        case (s)
            S_ACCUM, S_DRAIN: sel = SEL_FEEDBACK;
            default:          sel = SEL_LOAD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/addsub_seq.sv
// Job sequencer that streams operands into a 2-cycle registered add/sub
// datapath, tracks in-flight issues and returns the final sum and sticky carry.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int N  = 16,
    parameter int LW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_sub,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [N-1:0]  op_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_ovf,
    output logic [N-1:0]  dp_A,
    output logic [N-1:0]  dp_B,
    output logic          dp_Sel,
    output logic          dp_AddSub,
    input  logic [N-1:0]  dp_Z,
    input  logic          dp_Overflow
);

    localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [LW-1:0] cnt;
    logic [1:0]    v;
    logic          sticky;
    logic          sub;
    logic          issue;

    assign cmd_ready = (state == S_IDLE) & ~Reset;
    assign op_ready  = (state == S_FIRST) | (state == S_ACCUM);
    assign res_valid = (state == S_DONE);
    assign issue     = op_valid & op_ready;

    // Datapath drive: a hold adds zero, FIRST loads via the A path, ACCUM feeds back Z.
    always_comb begin
        dp_A      = {N{1'b0}};
        dp_B      = {N{1'b0}};
        dp_Sel    = hold_sel(state);
        dp_AddSub = HOLD_ADDSUB;
        case (state)
            S_FIRST: begin
                if (issue) begin
                    dp_A   = op_data;
                    dp_Sel = SEL_LOAD;
                end else begin
                    dp_A = {N{1'b0}};
                end
            end
            S_ACCUM: begin
                if (issue) begin
                    dp_B      = op_data;
                    dp_Sel    = SEL_FEEDBACK;
                    dp_AddSub = sub;
                end else begin
                    dp_B = {N{1'b0}};
                end
            end
            default: begin
                dp_A = {N{1'b0}};
            end
        endcase
    end

    // Controller FSM, issue pipeline tracking and result capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= {LW{1'b0}};
            v        <= 2'b00;
            sticky   <= 1'b0;
            sub      <= 1'b0;
            res_data <= {N{1'b0}};
            res_ovf  <= 1'b0;
        end else begin
            v <= {v[0], issue};
            if (v[1]) begin
                sticky <= sticky | dp_Overflow;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == {LW{1'b0}}) begin
                            res_data <= {N{1'b0}};
                            res_ovf  <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            sub    <= cmd_sub;
                            cnt    <= cmd_len;
                            sticky <= 1'b0;
                            state  <= S_FIRST;
                        end
                    end
                end
                S_FIRST, S_ACCUM: begin
                    if (issue) begin
                        cnt   <= cnt - CNT_ONE;
                        state <= (cnt == CNT_ONE) ? S_DRAIN : S_ACCUM;
                    end
                end
                S_DRAIN: begin
                    // The last issue has reached Z once it is two stages old with nothing behind it.
                    if (v[1] && !v[0]) begin
                        res_data <= dp_Z;
                        res_ovf  <= sticky | dp_Overflow;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
